// File: rtl/uart_arbiter_pkg.sv
// ============================================================================
// Module      : uart_arbiter_pkg
// Description : Shared definitions for the UART arbiter and for users of the
//               UART controller.
//               - Controller status bit indices.
//               - Arbiter FSM state encoding.
//               - Helper that turns a requester index into an ack mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_arbiter_pkg;

    // Bit positions inside the controller's uart_status byte.
    localparam int c_TX_NOT_FULL  = 0;
    localparam int c_TX_EMPTY     = 1;
    localparam int c_RX_NOT_EMPTY = 2;

    // Arbiter FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_SETTLE  = 2'd3
    } arb_state_t;

    // Requester index -> one-hot ack mask.
    function automatic logic [1:0] idx_to_mask(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage : uart_arbiter_pkg

`default_nettype wire

// File: rtl/uart_arbiter_rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin pick. When both requesters are eligible,
//               the one that was not granted last wins. When only one is
//               eligible, it wins.
// Ports       : eligible[1:0] - per-requester eligibility
//               last          - index granted most recently
//               grant         - chosen index (meaningful when valid=1)
//               valid         - at least one requester is eligible
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |eligible;
        if (eligible == 2'b11) begin
            grant = ~last;
        end else begin
            // Single eligible requester (or none, where grant is ignored).
            grant = eligible[1];
        end
    end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/uart_arbiter.sv
// ============================================================================
// Module      : uart_arbiter
// Description : Arbitrates two requesters onto one UART controller port.
//               Writes push one byte into the controller. Reads pop one byte
//               after READ_LAT cycles, or complete empty when RX has no data.
//               Each transaction is followed by SETTLE idle cycles, so the
//               controller status seen at the next grant reflects it.
// Ports       : clk, rst            - clock, async active-high reset
//               req_wr/req_rd[1:0]  - level requests, held until ack
//               req_data0/1         - write byte per requester
//               ack[1:0]            - one-cycle completion pulse
//               rdata, rd_empty     - read result, valid in the ack cycle
//               uart_wr_en          - write strobe to the controller
//               uart_read           - read strobe to the controller
//               uart_data           - write data to the controller
//               uart_status         - controller status byte
//               uart_data_out       - controller RX FIFO head
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_arbiter
    import uart_arbiter_pkg::*;
#(
    parameter int READ_LAT = 3,   // >= 1
    parameter int SETTLE   = 2    // >= 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_wr,
    input  logic [1:0]  req_rd,
    input  logic [7:0]  req_data0,
    input  logic [7:0]  req_data1,
    output logic [1:0]  ack,
    output logic [7:0]  rdata,
    output logic        rd_empty,
    output logic        uart_wr_en,
    output logic        uart_read,
    output logic [15:0] uart_data,
    input  logic [7:0]  uart_status,
    input  logic [7:0]  uart_data_out
);

    localparam logic [7:0] c_RD_LAST     = 8'(READ_LAT - 1);
    localparam logic [7:0] c_SETTLE_LAST = 8'(SETTLE - 1);

    arb_state_t r_state;
    logic [7:0] r_cnt;
    logic       r_last;     // index granted most recently
    logic       r_gnt;      // index owning the current transaction

    logic       w_tx_ok;
    logic       w_rx_ok;
    logic [1:0] w_eligible;
    logic       w_gnt;
    logic       w_valid;
    logic       w_gnt_wr;
    logic [7:0] w_gnt_data;
    logic       w_unused_status;

    assign w_tx_ok = uart_status[c_TX_NOT_FULL];
    assign w_rx_ok = uart_status[c_RX_NOT_EMPTY];

    // A write blocked by a full TX FIFO makes its requester ineligible, so the
    // other requester can still be served in the same cycle. A write also
    // masks a simultaneous read from the same requester.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_elig
            assign w_eligible[gi] = req_wr[gi] ? w_tx_ok : req_rd[gi];
        end
    endgenerate

    rr_arb2 u_rr_arb2 (
        .eligible (w_eligible),
        .last     (r_last),
        .grant    (w_gnt),
        .valid    (w_valid)
    );

    assign w_gnt_wr   = req_wr[w_gnt];
    assign w_gnt_data = w_gnt ? req_data1 : req_data0;

    assign w_unused_status = &{1'b0, uart_status[7:3], uart_status[c_TX_EMPTY]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_last     <= 1'b1;     // requester 0 wins the first tie
            r_gnt      <= 1'b0;
            ack        <= '0;
            rdata      <= '0;
            rd_empty   <= 1'b0;
            uart_wr_en <= 1'b0;
            uart_read  <= 1'b0;
            uart_data  <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            ack        <= '0;
            rd_empty   <= 1'b0;
            uart_wr_en <= 1'b0;
            uart_read  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_last <= w_gnt;
                        r_gnt  <= w_gnt;
                        r_cnt  <= '0;
                        if (w_gnt_wr) begin
                            uart_wr_en <= 1'b1;
                            uart_data  <= {8'h00, w_gnt_data};
                            r_state    <= ST_WR;
                        end else if (w_rx_ok) begin
                            uart_read <= 1'b1;
                            r_state   <= ST_RD_WAIT;
                        end else begin
                            // Nothing to read: complete immediately as empty.
                            ack      <= idx_to_mask(w_gnt);
                            rd_empty <= 1'b1;
                            rdata    <= '0;
                            r_state  <= ST_SETTLE;
                        end
                    end
                end

                ST_WR: begin
                    ack     <= idx_to_mask(r_gnt);
                    r_cnt   <= '0;
                    r_state <= ST_SETTLE;
                end

                ST_RD_WAIT: begin
                    if (r_cnt == c_RD_LAST) begin
                        rdata   <= uart_data_out;
                        ack     <= idx_to_mask(r_gnt);
                        r_cnt   <= '0;
                        r_state <= ST_SETTLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                ST_SETTLE: begin
                    // The ack cycle is the first settle cycle.
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : uart_arbiter

`default_nettype wire

// File: tb/tb_uart_arbiter.sv
// ============================================================================
// Module      : tb_uart_arbiter
// Description : Self-checking bench for uart_arbiter. Table of directed
//               transactions, hand-written multi-cycle sequences, and
//               randomized transactions predicted by a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_arbiter;

    localparam int READ_LAT = 3;
    localparam int SETTLE   = 2;

    localparam int K_NONE  = 0;
    localparam int K_WR    = 1;
    localparam int K_RD    = 2;
    localparam int K_EMPTY = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_wr;
    logic [1:0]  req_rd;
    logic [7:0]  req_data0;
    logic [7:0]  req_data1;
    logic [1:0]  ack;
    logic [7:0]  rdata;
    logic        rd_empty;
    logic        uart_wr_en;
    logic        uart_read;
    logic [15:0] uart_data;
    logic [7:0]  uart_status;
    logic [7:0]  uart_data_out;

    always #5 clk = ~clk;

    uart_arbiter #(
        .READ_LAT (READ_LAT),
        .SETTLE   (SETTLE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_wr        (req_wr),
        .req_rd        (req_rd),
        .req_data0     (req_data0),
        .req_data1     (req_data1),
        .ack           (ack),
        .rdata         (rdata),
        .rd_empty      (rd_empty),
        .uart_wr_en    (uart_wr_en),
        .uart_read     (uart_read),
        .uart_data     (uart_data),
        .uart_status   (uart_status),
        .uart_data_out (uart_data_out)
    );

    int n_checks = 0;
    int n_errors = 0;
    int m_last;     // model: requester granted most recently

    typedef struct {
        logic [1:0] rw;
        logic [1:0] rr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] st;
        logic [7:0] dout;
        int         kind;
        int         idx;
        logic [7:0] val;
    } vec_t;

    vec_t tbl [11];

    task automatic chk_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [1:0] rw, input logic [1:0] rr,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] st, input logic [7:0] dout);
        req_wr        = rw;
        req_rd        = rr;
        req_data0     = d0;
        req_data1     = d1;
        uart_status   = st;
        uart_data_out = dout;
    endtask

    task automatic clear_reqs();
        req_wr = 2'b00;
        req_rd = 2'b00;
    endtask

    // Transaction-level prediction: which requester is served and how.
    task automatic predict(input logic [1:0] rw, input logic [1:0] rr,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] st, input logic [7:0] dout,
                           output int kind, output int idx, output logic [7:0] val);
        bit can [2];
        for (int i = 0; i < 2; i++)
            can[i] = rw[i] ? st[0] : rr[i];
        kind = K_NONE;
        idx  = 0;
        val  = 8'h00;
        if (can[0] || can[1]) begin
            if (can[0] && can[1]) idx = (m_last == 0) ? 1 : 0;
            else                  idx = can[0] ? 0 : 1;
            if (rw[idx]) begin
                kind = K_WR;
                val  = (idx == 0) ? d0 : d1;
            end else if (st[2]) begin
                kind = K_RD;
                val  = dout;
            end else begin
                kind = K_EMPTY;
            end
        end
    endtask

    // Observes one transaction from the cycle after its inputs were applied.
    // Cycle 1 is the first sample after the grant edge.
    task automatic run_txn(input int kind, input int idx, input logic [7:0] val,
                           input string name);
        int         wr_at  = -1;
        int         rd_at  = -1;
        int         ack_at = -1;
        int         win;
        logic [15:0] wdata = '0;
        logic [7:0]  rdv   = '0;
        logic        emp   = 1'b0;
        logic [1:0]  ackv  = '0;
        win = (kind == K_NONE) ? 10 : READ_LAT + 6;
        for (int c = 1; c <= win; c++) begin
            step();
            if (uart_wr_en && wr_at < 0) begin wr_at = c; wdata = uart_data; end
            if (uart_read && rd_at < 0) rd_at = c;
            if (ack != 2'b00 && ack_at < 0) begin
                ack_at = c; ackv = ack; rdv = rdata; emp = rd_empty;
            end
            if (ack_at >= 0 && kind != K_NONE) break;
        end
        case (kind)
            K_NONE: begin
                chk_eq({name, " ack_cycle"}, ack_at, -1);
                chk_eq({name, " wr_cycle"},  wr_at,  -1);
                chk_eq({name, " rd_cycle"},  rd_at,  -1);
            end
            K_WR: begin
                chk_eq({name, " wr_cycle"},  wr_at, 1);
                chk_eq({name, " uart_data"}, int'(wdata), int'({8'h00, val}));
                chk_eq({name, " ack_cycle"}, ack_at, 2);
                chk_eq({name, " ack"},       int'(ackv), 1 << idx);
                chk_eq({name, " rd_cycle"},  rd_at, -1);
            end
            K_RD: begin
                chk_eq({name, " rd_cycle"},  rd_at, 1);
                chk_eq({name, " ack_cycle"}, ack_at, 1 + READ_LAT);
                chk_eq({name, " ack"},       int'(ackv), 1 << idx);
                chk_eq({name, " rdata"},     int'(rdv), int'(val));
                chk_eq({name, " rd_empty"},  int'(emp), 0);
                chk_eq({name, " wr_cycle"},  wr_at, -1);
            end
            default: begin
                chk_eq({name, " ack_cycle"}, ack_at, 1);
                chk_eq({name, " ack"},       int'(ackv), 1 << idx);
                chk_eq({name, " rdata"},     int'(rdv), 0);
                chk_eq({name, " rd_empty"},  int'(emp), 1);
                chk_eq({name, " rd_cycle"},  rd_at, -1);
                chk_eq({name, " wr_cycle"},  wr_at, -1);
            end
        endcase
        if (kind != K_NONE) begin
            // Served requester drops its request; wait out the settle period.
            req_wr[idx] = 1'b0;
            req_rd[idx] = 1'b0;
            repeat (SETTLE) step();
        end
    endtask

    // Always-on exclusivity checks.
    always @(negedge clk) begin
        if (!rst) begin
            chk_eq("strobe_exclusive", int'(uart_wr_en && uart_read), 0);
            chk_eq("ack_onehot", int'($countones(ack) > 1), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          kind;
        int          idx;
        logic [7:0]  val;
        logic [1:0]  rw;
        logic [1:0]  rr;
        logic [7:0]  d0, d1, st, dout;
        int          ack_at;
        int          nw, na;
        int          wtime [4];
        int          atime [4];
        logic [15:0] wsrc  [4];
        logic [1:0]  aval  [4];

        //            rw     rr     d0     d1     st     dout   kind     idx val
        tbl[0]  = '{2'b01, 2'b00, 8'hA5, 8'h00, 8'h03, 8'h00, K_WR,    0, 8'hA5};
        tbl[1]  = '{2'b00, 2'b10, 8'h00, 8'h00, 8'h04, 8'h3C, K_RD,    1, 8'h3C};
        tbl[2]  = '{2'b00, 2'b01, 8'h00, 8'h00, 8'h00, 8'hEE, K_EMPTY, 0, 8'h00};
        tbl[3]  = '{2'b11, 2'b00, 8'h11, 8'h22, 8'h01, 8'h00, K_WR,    1, 8'h22};
        tbl[4]  = '{2'b11, 2'b00, 8'h33, 8'h44, 8'h01, 8'h00, K_WR,    0, 8'h33};
        tbl[5]  = '{2'b01, 2'b01, 8'h55, 8'h00, 8'h05, 8'h99, K_WR,    0, 8'h55};
        tbl[6]  = '{2'b01, 2'b10, 8'h66, 8'h00, 8'h04, 8'h77, K_RD,    1, 8'h77};
        tbl[7]  = '{2'b01, 2'b00, 8'h66, 8'h00, 8'h00, 8'h00, K_NONE,  0, 8'h00};
        tbl[8]  = '{2'b01, 2'b00, 8'h66, 8'h00, 8'h01, 8'h00, K_WR,    0, 8'h66};
        tbl[9]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h07, 8'h12, K_NONE,  0, 8'h00};
        tbl[10] = '{2'b10, 2'b10, 8'h00, 8'h88, 8'h04, 8'h34, K_NONE,  0, 8'h00};

        rst = 1'b1;
        apply(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        m_last = 1;

        // Reset state.
        @(negedge clk);
        chk_eq("reset ack",        int'(ack), 0);
        chk_eq("reset rdata",      int'(rdata), 0);
        chk_eq("reset rd_empty",   int'(rd_empty), 0);
        chk_eq("reset uart_wr_en", int'(uart_wr_en), 0);
        chk_eq("reset uart_read",  int'(uart_read), 0);
        chk_eq("reset uart_data",  int'(uart_data), 0);
        step();
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].rw, tbl[i].rr, tbl[i].d0, tbl[i].d1, tbl[i].st, tbl[i].dout);
            run_txn(tbl[i].kind, tbl[i].idx, tbl[i].val, $sformatf("vec%0d", i));
            if (tbl[i].kind != K_NONE) m_last = tbl[i].idx;
            clear_reqs();
        end

        // Blocked write is held while the other requester's read is served,
        // then completes once TX space appears.
        apply(2'b01, 2'b10, 8'hC3, 8'h00, 8'h04, 8'h81);
        run_txn(K_RD, 1, 8'h81, "held_rd1");
        run_txn(K_NONE, 0, 8'h00, "held_blocked");
        uart_status = 8'h01;
        run_txn(K_WR, 0, 8'hC3, "held_wr0");
        m_last = 0;
        clear_reqs();

        // Read request dropped right after the uart_read pulse still acks.
        apply(2'b00, 2'b10, 8'h00, 8'h00, 8'h04, 8'h5E);
        step();
        chk_eq("drop uart_read", int'(uart_read), 1);
        clear_reqs();
        ack_at = -1;
        for (int c = 2; c <= READ_LAT + 6; c++) begin
            step();
            if (ack != 2'b00) begin
                ack_at = c;
                chk_eq("drop ack", int'(ack), 2);
                chk_eq("drop rdata", int'(rdata), 8'h5E);
                break;
            end
        end
        chk_eq("drop ack_cycle", ack_at, 1 + READ_LAT);
        repeat (SETTLE) step();
        m_last = 1;

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            rw   = 2'($urandom_range(0, 3));
            rr   = 2'($urandom_range(0, 3));
            d0   = 8'($urandom);
            d1   = 8'($urandom);
            st   = 8'($urandom);
            dout = 8'($urandom);
            apply(rw, rr, d0, d1, st, dout);
            predict(rw, rr, d0, d1, st, dout, kind, idx, val);
            run_txn(kind, idx, val, $sformatf("rnd%0d", i));
            if (kind != K_NONE) m_last = idx;
            clear_reqs();
        end

        // Reset asserted during RD_WAIT.
        apply(2'b00, 2'b01, 8'h00, 8'h00, 8'h04, 8'h9A);
        run_txn(K_RD, 0, 8'h9A, "pre_rst_read");
        clear_reqs();
        apply(2'b00, 2'b10, 8'h00, 8'h00, 8'h04, 8'h12);
        step();
        chk_eq("rst_mid uart_read", int'(uart_read), 1);
        step();
        rst = 1'b1;
        #1;
        chk_eq("rst_mid ack",        int'(ack), 0);
        chk_eq("rst_mid rdata",      int'(rdata), 0);
        chk_eq("rst_mid rd_empty",   int'(rd_empty), 0);
        chk_eq("rst_mid uart_wr_en", int'(uart_wr_en), 0);
        chk_eq("rst_mid uart_read",  int'(uart_read), 0);
        chk_eq("rst_mid uart_data",  int'(uart_data), 0);
        clear_reqs();
        step();
        step();
        rst = 1'b0;
        m_last = 1;
        run_txn(K_NONE, 0, 8'h00, "post_rst_idle");

        // Continuous writes from both: order 0,1,0,1 from the reset pointer.
        apply(2'b11, 2'b00, 8'hA0, 8'hB1, 8'h01, 8'h00);
        nw = 0;
        na = 0;
        for (int c = 1; c <= 40 && na < 4; c++) begin
            step();
            if (uart_wr_en && nw < 4) begin wtime[nw] = c; wsrc[nw] = uart_data; nw++; end
            if (ack != 2'b00 && na < 4) begin atime[na] = c; aval[na] = ack; na++; end
        end
        clear_reqs();
        chk_eq("cont ack_count", na, 4);
        chk_eq("cont wr_count", nw, 4);
        if (nw == 4 && na == 4) begin
            chk_eq("cont first_wr", wtime[0], 1);
            for (int k = 0; k < 4; k++) begin
                chk_eq($sformatf("cont data%0d", k), int'(wsrc[k]),
                       (k % 2 == 0) ? 16'h00A0 : 16'h00B1);
                chk_eq($sformatf("cont ack%0d", k), int'(aval[k]),
                       (k % 2 == 0) ? 1 : 2);
                chk_eq($sformatf("cont ack_lat%0d", k), atime[k] - wtime[k], 1);
                if (k > 0)
                    chk_eq($sformatf("cont spacing%0d", k),
                           wtime[k] - wtime[k-1], SETTLE + 2);
            end
        end
        repeat (SETTLE + 1) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_arbiter

`default_nettype wire

// File: doc/uart_arbiter.md
UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 Parameter READ_LAT, default 3, cycles from uart_read pulse to valid uart_data_out capture.
REQ-002 Parameter SETTLE, default 2, idle cycles after each transaction so the registered controller status reflects that transaction.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_wr[1:0]  in  2  per-requester write request, level, held until ack.
REQ-006 req_rd[1:0]  in  2  per-requester read request, level, held until ack.
REQ-007 req_data0, req_data1  in  8 each  write byte per requester.
REQ-008 ack[1:0]  out  2  one-cycle completion pulse per requester.
REQ-009 rdata  out  8  read byte, valid in the ack cycle.
REQ-010 rd_empty  out  1  in the ack cycle of a read, 1 if no byte was available.
REQ-011 uart_wr_en, uart_read  out  1 each  one-cycle pulses to the UART controller.
REQ-012 uart_data  out  16  write data to controller; [7:0] = byte, [15:8] = 0.
REQ-013 uart_status  in  8  controller status; bit0 = TX not full, bit2 = RX not empty.
REQ-014 uart_data_out  in  8  controller RX FIFO head.

Function
REQ-015 FSM states IDLE, WR, RD_WAIT, SETTLE; all outputs registered.
REQ-016 IDLE: requester i is eligible if req_wr[i], or req_rd[i] with req_wr[i]=0.
REQ-017 Both eligible: grant the requester not granted last (round-robin pointer); one eligible: grant it.
REQ-018 Granted write with uart_status[0]=1: next edge uart_wr_en=1, uart_data={8'h0,req_data}, state WR.
REQ-019 Granted write with uart_status[0]=0: no grant, pointer unchanged, stay IDLE; the other requester is evaluated the same cycle.
REQ-020 WR (1 cycle): uart_wr_en returns to 0, ack[g] pulses next cycle, SETTLE entered.
REQ-021 Granted read with uart_status[2]=1: uart_read pulses 1 cycle, RD_WAIT counts READ_LAT cycles, then rdata<=uart_data_out, rd_empty<=0, ack[g] pulse, SETTLE.
REQ-022 Granted read with uart_status[2]=0: next cycle ack[g] pulse, rd_empty=1, rdata=0, no uart_read, SETTLE.
REQ-023 req_wr and req_rd both high on one requester: only the write is performed.
REQ-024 Request dropped mid-transaction: transaction completes, ack still pulses.
REQ-025 SETTLE counts SETTLE cycles, then IDLE; no grants during SETTLE.
REQ-026 Pointer updates to the granted index at grant time.
REQ-027 At most one of uart_wr_en / uart_read high in any cycle; at most one ack bit per cycle.

Reset
REQ-028 rst=1 immediately forces state IDLE, pointer = requester 1 (requester 0 wins first tie), counters 0, all outputs 0 including rdata; mid-transaction work is abandoned with no ack.

Structure
REQ-029 Shared header uart_defs.vh holds status bit indices (TX_NOT_FULL=0, TX_EMPTY=1, RX_NOT_EMPTY=2) and FSM state encodings, shared with uart_controller users.
REQ-030 One sub-module rr_arb2 (2-way round-robin pick: eligible[1:0], last -> grant index, valid).
REQ-031 uart_arbiter instantiates rr_arb2 only; the UART controller is instantiated one level up.

Verification
REQ-032 Req0 write 8'hA5, status=8'h03 -> uart_wr_en 1 cycle with uart_data=16'h00A5, ack[0] next cycle, no new grant for 2 cycles.
REQ-033 Req0 and req1 write continuously, status bit0=1 -> uart_wr_en order 0,1,0,1; acks alternate.
REQ-034 Req1 read, status bit2=1, uart_data_out=8'h3C -> uart_read pulse, ack[1] 3 cycles later with rdata=8'h3C, rd_empty=0.
REQ-035 Req0 read, status bit2=0 -> ack[0] with rd_empty=1, rdata=0, uart_read never asserted.
REQ-036 Req0 write with status bit0=0 and req1 read with bit2=1 -> req1 served, req0 held; req0 served after bit0 rises.
REQ-037 rst asserted during RD_WAIT -> outputs 0 asynchronously, no ack; after release, a new request completes normally.
